fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller that owns the program counter's pc_inc/pc_load controls.
//  It fetches the word at the current PC over a req/ack memory port and presents it to
//  decode over a valid/ready handshake. It advances the PC after each fetch and applies
//  branch/jump redirects. It sits between the program counter, instruction memory and decode.
// PARAMETERS
//  ADDR_W   16   PC / memory address width
//  DATA_W   16   instruction word width
//  TIMEOUT  255  max cycles in REQ without mem_ack before fault; 0 = timeout disabled
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       async active-low reset
//  run            in   1       level: 1 = fetch continuously, 0 = stop at next boundary
//  halt_req       in   1       level: stop after current instruction is consumed
//  pc             in   ADDR_W  current PC from program counter
//  pc_inc         out  1       PC increment strobe (one cycle)
//  pc_load        out  1       PC load strobe (one cycle)
//  pc_d           out  ADDR_W  PC load value
//  mem_req        out  1       fetch request, held until mem_ack
//  mem_addr       out  ADDR_W  fetch address (= pc, combinational)
//  mem_ack        in   1       memory data valid / request done
//  mem_rdata      in   DATA_W  fetched word, valid with mem_ack
//  instr_valid    out  1       instr holds an unconsumed instruction
//  instr          out  DATA_W  registered instruction word
//  instr_ready    in   1       decode accepts instr
//  redirect       in   1       one-cycle pulse: jump to redirect_addr
//  redirect_addr  in   ADDR_W  redirect target
//  busy           out  1       state != IDLE
//  fault          out  1       sticky fetch-timeout flag
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; all strobes, mem_req, instr_valid, fault = 0;
//   instr=0; pending redirect cleared; timeout counter=0.
//  pc_inc and pc_load are never asserted in the same cycle (the PC gives inc priority).
//  States:
//   IDLE : run & !halt_req -> REQ. A redirect in IDLE: pc_load=1 with pc_d=redirect_addr,
//          and the state stays IDLE (sets the start address).
//   REQ  : mem_req=1, mem_addr=pc. On mem_ack:
//          - no pending redirect: instr<=mem_rdata, pc_inc=1, -> ISSUE.
//          - pending redirect (incl. redirect in the ack cycle): discard data,
//            pc_load=1 with pc_d=pending/redirect addr, clear pending, -> REQ.
//          A redirect without ack is stored as pending; a later redirect overwrites it.
//          pc is never changed while mem_req=1.
//   ISSUE: instr_valid=1 and instr is stable until handshake (instr_valid & instr_ready).
//          - redirect (with or without handshake): pc_load=1 in that cycle,
//            instr_valid=0 next cycle, -> REQ.
//          - handshake, no redirect: -> IDLE if halt_req | !run, else -> REQ.
//   FAULT: entered when TIMEOUT!=0 and REQ has lasted TIMEOUT cycles without mem_ack.
//          mem_req=0, instr_valid=0, fault=1. Exit only by reset; run and redirect are ignored.
//  The timeout counter clears on REQ entry and counts each REQ cycle without ack.
//  halt_req / !run never abort an outstanding fetch; REQ always completes to ISSUE first.
//  Latency: run=1 in IDLE -> mem_req on the next cycle. Ack in cycle N -> instr_valid in
//   N+1, pc=pc+1 in N+1. With zero-wait memory and instr_ready=1, one instruction every 2 cycles.
//  PC wrap: 16'hFFFF + 1 = 16'h0000 (done by the counter). The sequencer has no special case.
// TESTING
//  1 run=1, PC=0, mem_ack same cycle as mem_req, instr_ready=1, words A0..A3 ->
//    instr=A0..A3 in order, PC 0->4, instr_valid every 2nd cycle, pc_load never set.
//  2 ISSUE with instr_ready=0 for 5 cycles -> instr_valid and instr held, no mem_req, no pc_inc.
//  3 redirect to 16'h0040 in the 2nd REQ wait cycle, ack 3 cycles later -> data dropped,
//    pc_load with pc_d=0x0040 in the ack cycle, next mem_addr=0x0040, no pc_inc.
//  4 redirect to 16'h0100 in ISSUE at the same cycle as the handshake -> pc_load=1, pc_inc=0,
//    next mem_addr=0x0100; halt_req=1 at a handshake -> IDLE, busy=0.
//  5 TIMEOUT=8, mem_ack held 0 -> fault=1 after 8 REQ cycles, mem_req=0; run toggles ignored.
//  6 rst_n low while in REQ and in ISSUE -> immediate IDLE, all outputs 0. PC=16'hFFFF fetch
//    -> pc_inc, next mem_addr=0x0000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: fetches the word at pc over a req/ack port, hands it to
// decode over valid/ready, and drives the program counter's pc_inc/pc_load strobes.
module fetch_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_d,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ISSUE,
    S_FAULT
  } state_e;

  localparam int               TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] instr_q;
  logic [TO_W-1:0]   to_cnt_q;

  assign mem_addr    = pc;
  assign mem_req     = (state_q == S_REQ);
  assign instr_valid = (state_q == S_ISSUE);
  assign fault       = (state_q == S_FAULT);
  assign busy        = (state_q != S_IDLE);
  assign instr       = instr_q;

  // PC strobes must act in the cycle of the event, so they are decoded, not registered.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    pc_d    = redirect_addr;
    unique case (state_q)
      S_IDLE:  pc_load = redirect;
      S_REQ: begin
        if (mem_ack) begin
          if (redirect || pend_q) begin
            pc_load = 1'b1;
            if (!redirect) pc_d = pend_addr_q;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      S_ISSUE: pc_load = redirect;
      S_FAULT: ;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      instr_q     <= '0;
      to_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!redirect && run && !halt_req) begin
            state_q  <= S_REQ;
            to_cnt_q <= '0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            pend_q   <= 1'b0;
            to_cnt_q <= '0;
            // A redirect seen during or before the ack drops this word and refetches.
            if (!(redirect || pend_q)) begin
              instr_q <= mem_rdata;
              state_q <= S_ISSUE;
            end
          end else begin
            if (redirect) begin
              pend_q      <= 1'b1;
              pend_addr_q <= redirect_addr;
            end
            if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
              state_q <= S_FAULT;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (redirect) begin
            state_q  <= S_REQ;
            to_cnt_q <= '0;
          end else if (instr_ready) begin
            state_q  <= (halt_req || !run) ? S_IDLE : S_REQ;
            to_cnt_q <= '0;
          end
        end
        S_FAULT: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
